// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and defaults for the data-memory controller.
package data_mem_ctrl_pkg;

    localparam int unsigned DMEM_AW = 8;
    localparam int unsigned DMEM_DW = 8;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        MemIdle,
        MemWait,
        MemResp
    } mem_state_t;

    // Counter preload on accept; a zero-wait build never enters MemWait.
    function automatic logic [CNT_W-1:0] wait_preload(int unsigned wait_cycles);
        return (wait_cycles == 0) ? '0 : CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port data RAM, synchronous read and write, no reset on contents.
module dmem_array #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one load/store per instruction with wait states and core stall.
// Optional write protection of addresses >= WP_BASE is enabled by defining DMEM_WP_EN.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned   DW          = DMEM_DW,
    parameter int unsigned   AW          = DMEM_AW,
    parameter int unsigned   WAIT_CYCLES = 1,
    parameter logic [AW-1:0] WP_BASE     = AW'('hF0)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_load_i,
    input  logic          req_stor_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] stor_data_i,
    output logic [DW-1:0] load_data_o,
    output logic          load_en_o,
    output logic          stall_o,
    output logic          conflict_o,
    output logic          wp_fault_o
);

`ifdef DMEM_WP_EN
    localparam bit WpEn = 1'b1;
`else
    localparam bit WpEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CntInit = wait_preload(WAIT_CYCLES);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;
    logic             is_store_q, is_store_d;
    logic             conflict_q, conflict_d;
    logic [DW-1:0]    load_data_q, load_data_d;

    logic             req;
    logic             resp;
    logic             wp_hit;
    logic             wp_block;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_rdata;

    assign req  = req_load_i | req_stor_i;
    assign resp = (state_q == MemResp);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        is_store_d = is_store_q;
        conflict_d = 1'b0;
        unique case (state_q)
            MemIdle: begin
                if (req) begin
                    addr_d     = addr_i;
                    // Only a real store samples storData; it may float otherwise.
                    data_d     = req_stor_i ? stor_data_i : data_q;
                    is_store_d = req_stor_i;
                    conflict_d = req_load_i & req_stor_i;
                    cnt_d      = CntInit;
                    state_d    = (WAIT_CYCLES > 0) ? MemWait : MemResp;
                end
            end
            MemWait: begin
                if (cnt_q == '0) begin
                    state_d = MemResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MemResp: state_d = MemIdle;
            default: state_d = MemIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MemIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            is_store_q  <= 1'b0;
            conflict_q  <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            is_store_q  <= is_store_d;
            conflict_q  <= conflict_d;
            load_data_q <= load_data_d;
        end
    end

    assign wp_hit   = (addr_q >= WP_BASE);
    assign wp_block = WpEn & is_store_q & wp_hit;

    // Writes land on the edge leaving RESP; reads are captured on the edge entering it.
    assign ram_we   = resp & is_store_q & ~wp_block;
    assign ram_addr = (state_q == MemIdle) ? addr_i : addr_q;

    dmem_array #(
        .DW(DW),
        .AW(AW)
    ) u_dmem_array (
        .clk    (clk),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(data_q),
        .rdata_o(ram_rdata)
    );

    assign load_en_o   = resp & ~is_store_q;
    assign load_data_o = load_en_o ? ram_rdata : load_data_q;
    assign load_data_d = load_data_o;

    assign stall_o    = ((state_q == MemIdle) & req) | (state_q == MemWait);
    assign conflict_o = conflict_q;
    assign wp_fault_o = resp & wp_block;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: two controllers (1 and 3 wait states) against a per-instruction timeline model.
module tb_data_mem_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       req_ld [2];
    logic       req_st [2];
    logic [7:0] addr   [2];
    logic [7:0] sdata  [2];
    logic [7:0] ld_data[2];
    logic       ld_en  [2];
    logic       stall  [2];
    logic       conf   [2];
    logic       wpf    [2];

    data_mem_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_load_i(req_ld[0]), .req_stor_i(req_st[0]),
        .addr_i(addr[0]), .stor_data_i(sdata[0]), .load_data_o(ld_data[0]),
        .load_en_o(ld_en[0]), .stall_o(stall[0]), .conflict_o(conf[0]), .wp_fault_o(wpf[0])
    );

    data_mem_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_load_i(req_ld[1]), .req_stor_i(req_st[1]),
        .addr_i(addr[1]), .stor_data_i(sdata[1]), .load_data_o(ld_data[1]),
        .load_en_o(ld_en[1]), .stall_o(stall[1]), .conflict_o(conf[1]), .wp_fault_o(wpf[1])
    );

    // Model: memory image per instance plus expected outputs for the current cycle.
    logic [7:0] mem_m [2][256];
    bit         known [2][256];
    bit         e_stall[2], e_len[2], e_conf[2], e_wp[2], e_ld_ok[2];
    logic [7:0] e_ld[2];
    bit         run_cmp = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic bit wp_prot(input logic [7:0] a);
`ifdef DMEM_WP_EN
        return a >= 8'hF0;
`else
        return (a != a);
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("stall[%0d]", i), 8'(stall[i]), 8'(e_stall[i]));
                chk($sformatf("load_en[%0d]", i), 8'(ld_en[i]), 8'(e_len[i]));
                chk($sformatf("conflict[%0d]", i), 8'(conf[i]), 8'(e_conf[i]));
                chk($sformatf("wp_fault[%0d]", i), 8'(wpf[i]), 8'(e_wp[i]));
                if (e_ld_ok[i]) chk($sformatf("load_data[%0d]", i), ld_data[i], e_ld[i]);
            end
        end
    end

    task automatic set_idle(input int j);
        req_ld[j]  = 1'b0;
        req_st[j]  = 1'b0;
        addr[j]    = 8'($urandom);
        sdata[j]   = 8'($urandom);
        e_stall[j] = 1'b0;
        e_len[j]   = 1'b0;
        e_conf[j]  = 1'b0;
        e_wp[j]    = 1'b0;
    endtask

    task automatic set_reset_exp();
        for (int j = 0; j < 2; j++) begin
            set_idle(j);
            e_ld[j]    = 8'h00;
            e_ld_ok[j] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            set_idle(0);
            set_idle(1);
        end
    endtask

    // One instruction: request in cycle 0, wait cycles 1..W, response in cycle W+1.
    task automatic run_op(input int i, input bit ld, input bit st, input logic [7:0] a,
                          input logic [7:0] d, input bit hold);
        int w;
        w = (i == 0) ? 1 : 3;
        for (int c = 0; c <= w + 1; c++) begin
            @(posedge clk); #1;
            set_idle(1 - i);
            req_ld[i]  = (c == 0 || hold) ? ld : 1'b0;
            req_st[i]  = (c == 0 || hold) ? st : 1'b0;
            addr[i]    = (c == 0 || hold) ? a : 8'($urandom);
            sdata[i]   = (c == 0 || hold) ? d : 8'($urandom);
            e_stall[i] = (c <= w);
            e_conf[i]  = (c == 1) && ld && st;
            e_wp[i]    = (c == w + 1) && st && wp_prot(a);
            e_len[i]   = (c == w + 1) && ld && !st;
            if (e_len[i]) begin
                e_ld[i]    = mem_m[i][a];
                e_ld_ok[i] = known[i][a];
            end
        end
        if (st && !wp_prot(a)) begin
            mem_m[i][a] = d;
            known[i][a] = 1'b1;
        end
    endtask

    initial begin
        set_reset_exp();
        #1 rst_n = 1'b0;
        run_cmp = 1'b1;
        #20 rst_n = 1'b1;
        idle(1);

        // Seed address 0 on both instances.
        run_op(0, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b0);
        run_op(1, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b0);

        // Store then back-to-back load of the same address.
        run_op(0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
        run_op(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        chk("t1 load_en in cycle 2", 8'(ld_en[0]), 8'h01);
        chk("t1 load_data", ld_data[0], 8'hA5);
        idle(1);

        // Three wait states, load request held through the response cycle.
        run_op(1, 1'b0, 1'b1, 8'h33, 8'hC7, 1'b0);
        idle(1);
        run_op(1, 1'b1, 1'b0, 8'h33, 8'h00, 1'b1);
        chk("t2 load_en in cycle 4", 8'(ld_en[1]), 8'h01);
        chk("t2 load_data", ld_data[1], 8'hC7);
        idle(3);

        // Load and store together: store wins.
        run_op(0, 1'b1, 1'b1, 8'h20, 8'h3C, 1'b0);
        chk("t3 no load_en", 8'(ld_en[0]), 8'h00);
        idle(1);
        run_op(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        chk("t3 load_data", ld_data[0], 8'h3C);
        idle(1);

        // Reset during WAIT aborts a pending store.
        run_op(0, 1'b0, 1'b1, 8'h40, 8'h55, 1'b0);
        idle(1);
        @(posedge clk); #1;
        set_idle(1);
        req_st[0] = 1'b1; addr[0] = 8'h40; sdata[0] = 8'h11; e_stall[0] = 1'b1;
        @(posedge clk); #1;
        set_idle(0);
        e_stall[0] = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        set_reset_exp();
        #1;
        chk("t4 stall drops at reset", 8'(stall[0]), 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);
        run_op(0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
        chk("t4 store aborted", ld_data[0], 8'h55);
        idle(1);

        // Top and bottom of the address range.
        run_op(0, 1'b0, 1'b1, 8'hFF, 8'h7E, 1'b0);
        run_op(0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
        chk("t5 load FF", ld_data[0], 8'h7E);
        run_op(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("t5 load 00", ld_data[0], 8'h5A);
        run_op(1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("t5 load 00 w3", ld_data[1], 8'h5A);
        idle(1);

        // Store into the protectable region.
        run_op(0, 1'b0, 1'b1, 8'hF5, 8'h99, 1'b0);
`ifdef DMEM_WP_EN
        chk("t6 wp_fault", 8'(wpf[0]), 8'h01);
`else
        chk("t6 wp_fault", 8'(wpf[0]), 8'h00);
        idle(1);
        run_op(0, 1'b1, 1'b0, 8'hF5, 8'h00, 1'b0);
        chk("t6 load F5", ld_data[0], 8'h99);
`endif
        idle(2);
        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
